pci_ddr_window: RTL

Bridges the PCI target user port for the BAR1 memory window (128 KB) to the 64-bit DDR controller command/data port. It performs posted single-word writes and PCI delayed reads: the first read attempt is retried while the DDR read runs, and the repeated attempt completes with the captured data. The block sits between the PCI target core and the DDR controller in the user logic, both on the PCI clock. All accesses are retried until the controller reports init complete.

---
 rtl/pci_ddr_window.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pci_ddr_window.sv
// PCI BAR1 window to 64-bit DDR command port bridge.
// Writes are posted; reads are delayed (retry, fetch, then ack the repeated read).
module pci_ddr_window #(
  parameter int unsigned WIN_AW    = 17,
  parameter int unsigned DISCARD_W = 15
) (
  input  logic                PCI_CLK,
  input  logic                PCI_RSTn,
  input  logic                init_done,
  input  logic                t_req,
  input  logic                t_we,
  input  logic [WIN_AW-3:0]   t_addr,
  input  logic [31:0]         t_wdata,
  input  logic [3:0]          t_be,
  output logic                t_ack,
  output logic                t_retry,
  output logic [31:0]         t_rdata,
  output logic                rd_discard,
  output logic                d_cmd_valid,
  input  logic                d_cmd_ready,
  output logic                d_cmd_we,
  output logic [WIN_AW-4:0]   d_cmd_addr,
  output logic [63:0]         d_wdata,
  output logic [7:0]          d_wbe,
  input  logic                d_rdata_valid,
  input  logic [63:0]         d_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_DONE  = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [WIN_AW-3:0]      pend_addr, pend_addr_n;
  logic [31:0]            rd_lane, rd_lane_n;
  logic [DISCARD_W-1:0]   timer, timer_n;

  logic                   ack_n, retry_n, discard_n;
  logic [31:0]            rdata_n;
  logic                   cmd_valid_n, cmd_we_n;
  logic [WIN_AW-4:0]      cmd_addr_n;
  logic [63:0]            wdata_n;
  logic [7:0]             wbe_n;
  logic                   req_sample;
  logic                   rd_hit;

  // State and all registered outputs.
  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      state       <= IDLE;
      pend_addr   <= '0;
      rd_lane     <= '0;
      timer       <= '0;
      t_ack       <= 1'b0;
      t_retry     <= 1'b0;
      t_rdata     <= '0;
      rd_discard  <= 1'b0;
      d_cmd_valid <= 1'b0;
      d_cmd_we    <= 1'b0;
      d_cmd_addr  <= '0;
      d_wdata     <= '0;
      d_wbe       <= '0;
    end else begin
      state       <= state_n;
      pend_addr   <= pend_addr_n;
      rd_lane     <= rd_lane_n;
      timer       <= timer_n;
      t_ack       <= ack_n;
      t_retry     <= retry_n;
      t_rdata     <= rdata_n;
      rd_discard  <= discard_n;
      d_cmd_valid <= cmd_valid_n;
      d_cmd_we    <= cmd_we_n;
      d_cmd_addr  <= cmd_addr_n;
      d_wdata     <= wdata_n;
      d_wbe       <= wbe_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    pend_addr_n = pend_addr;
    rd_lane_n   = rd_lane;
    timer_n     = timer;
    ack_n       = 1'b0;
    retry_n     = 1'b0;
    discard_n   = 1'b0;
    rdata_n     = '0;
    cmd_valid_n = d_cmd_valid;
    cmd_we_n    = d_cmd_we;
    cmd_addr_n  = d_cmd_addr;
    wdata_n     = d_wdata;
    wbe_n       = d_wbe;
    // A request held across its own response cycle must not be taken twice.
    req_sample  = t_req && !t_ack && !t_retry;
    rd_hit      = req_sample && init_done && !t_we && (t_addr == pend_addr);

    unique case (state)
      IDLE: begin
        if (req_sample) begin
          if (!init_done) begin
            retry_n = 1'b1;
          end else if (t_we) begin
            ack_n       = 1'b1;
            cmd_valid_n = 1'b1;
            cmd_we_n    = 1'b1;
            cmd_addr_n  = t_addr[WIN_AW-3:1];
            wdata_n     = {t_wdata, t_wdata};
            wbe_n       = t_addr[0] ? {t_be, 4'h0} : {4'h0, t_be};
            state_n     = WR_ISSUE;
          end else begin
            retry_n     = 1'b1;
            pend_addr_n = t_addr;
            cmd_valid_n = 1'b1;
            cmd_we_n    = 1'b0;
            cmd_addr_n  = t_addr[WIN_AW-3:1];
            wdata_n     = '0;
            wbe_n       = '0;
            state_n     = RD_ISSUE;
          end
        end
      end
      WR_ISSUE, RD_ISSUE: begin
        retry_n = req_sample;
        if (d_cmd_ready) begin
          cmd_valid_n = 1'b0;
          state_n     = (state == WR_ISSUE) ? IDLE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        retry_n = req_sample;
        if (d_rdata_valid) begin
          rd_lane_n = pend_addr[0] ? d_rdata[63:32] : d_rdata[31:0];
          timer_n   = '0;
          state_n   = RD_DONE;
        end
      end
      RD_DONE: begin
        timer_n = timer + DISCARD_W'(1);
        // The claiming read beats the discard when both land in the same cycle.
        if (rd_hit) begin
          ack_n   = 1'b1;
          rdata_n = rd_lane;
          state_n = IDLE;
        end else begin
          retry_n = req_sample;
          if (&timer) begin
            discard_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
